// File: rtl/vtc_pkg.sv
// -----------------------------------------------------------------------------
// vtc_pkg -- shared constants and helpers for the parametrised video timing
// controller.
//
// Contents:
//   DEF_*          640x480@60 default timing constants
//   total()        active + front porch + sync + back porch
//   fits()         true when a value does not exceed 2**width (counter range check)
// -----------------------------------------------------------------------------
package vtc_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CNT_W    = 16;

    function automatic int total(input int active, input int fp,
                                 input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // A counter of 'width' bits can address 'value' distinct positions
    // (0..value-1) when value <= 2**width.
    function automatic bit fits(input int width, input int value);
        return longint'(value) <= (longint'(1) << width);
    endfunction

endpackage

// File: rtl/vtc_timing_axis.sv
// -----------------------------------------------------------------------------
// vtc_timing_axis -- one axis (horizontal or vertical) of the timing generator.
// Modulo-TOTAL counter with an increment enable plus combinational decode of
// the pre-increment count.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset (count -> 0)
//   inc_i     in   advance the count this cycle
//   cnt_o     out  current count, 0..TOTAL-1
//   last_o    out  count == TOTAL-1 (next increment wraps to 0)
//   zero_o    out  count == 0
//   sync_o    out  count inside the sync window
//   active_o  out  count inside the visible region
// -----------------------------------------------------------------------------
module vtc_timing_axis
    import vtc_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o,
    output logic             zero_o,
    output logic             sync_o,
    output logic             active_o
);

    localparam int TOTAL      = total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = ACTIVE + FP + SYNC;

    generate
        if (!fits(CNT_W, TOTAL)) begin : g_cnt_too_narrow
            $error("vtc_timing_axis: CNT_W too narrow for TOTAL");
        end
        if (FP == 0 || SYNC == 0 || BP == 0) begin : g_zero_interval
            $error("vtc_timing_axis: porch and sync widths must be non-zero");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_o = (cnt_q == CNT_W'(TOTAL - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign zero_o   = (cnt_q == '0);
    assign sync_o   = (cnt_q >= CNT_W'(SYNC_START)) && (cnt_q < CNT_W'(SYNC_END));
    assign active_o = (cnt_q < CNT_W'(ACTIVE));

endmodule

// File: rtl/vtc_param.sv
// -----------------------------------------------------------------------------
// vtc_param -- parametrised video timing controller (HS/VS, active video,
// coordinates, line/frame start strobes) with a pixel-clock enable.
//
// Ports:
//   clkin            in   system clock
//   reset            in   asynchronous active-high reset
//   pix_en           in   pixel tick; timing advances only when high
//   VGA_HS           out  horizontal sync, asserted level HS_POL
//   VGA_VS           out  vertical sync, asserted level VS_POL
//   activeVideo      out  current pixel is visible
//   horizontalValue  out  current column 0..H_TOTAL-1
//   verticalValue    out  current line 0..V_TOTAL-1
//   lineStart        out  one-clkin pulse at column 0
//   frameStart       out  one-clkin pulse at (0,0)
//   frameCount       out  frames since reset mod 256 (only with VTC_FRAME_CNT_EN)
//
// Optional feature macro: VTC_FRAME_CNT_EN adds the frameCount output.
//
// All outputs are registered from the pre-increment counter decode, so pixel
// (x,y) appears on the outputs at the same pix_en edge the counters leave it.
// -----------------------------------------------------------------------------
module vtc_param
    import vtc_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             pix_en,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             activeVideo,
    output logic [CNT_W-1:0] horizontalValue,
    output logic [CNT_W-1:0] verticalValue,
    output logic             lineStart,
    output logic             frameStart
`ifdef VTC_FRAME_CNT_EN
    ,
    output logic [7:0]       frameCount
`endif
);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_last, h_zero, h_sync, h_active;
    logic             v_zero, v_sync, v_active;
    // The frame boundary is recognised from v_cnt==0, so the vertical
    // wrap flag has no consumer.
    logic             v_last_unused;

    vtc_timing_axis #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .CNT_W (CNT_W)
    ) u_h_axis (
        .clk      (clkin),
        .rst      (reset),
        .inc_i    (pix_en),
        .cnt_o    (h_cnt),
        .last_o   (h_last),
        .zero_o   (h_zero),
        .sync_o   (h_sync),
        .active_o (h_active)
    );

    // Lines advance on the pixel tick that wraps the column counter, which
    // also keeps VS edges aligned to column 0.
    vtc_timing_axis #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .CNT_W (CNT_W)
    ) u_v_axis (
        .clk      (clkin),
        .rst      (reset),
        .inc_i    (pix_en && h_last),
        .cnt_o    (v_cnt),
        .last_o   (v_last_unused),
        .zero_o   (v_zero),
        .sync_o   (v_sync),
        .active_o (v_active)
    );

    logic             hs_q, vs_q, active_q, line_start_q, frame_start_q;
    logic [CNT_W-1:0] hval_q, vval_q;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            hs_q          <= ~HS_ON;
            vs_q          <= ~VS_ON;
            active_q      <= 1'b0;
            hval_q        <= '0;
            vval_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            // Strobes are refreshed every clkin so they last exactly one cycle.
            line_start_q  <= pix_en && h_zero;
            frame_start_q <= pix_en && h_zero && v_zero;
            if (pix_en) begin
                hs_q     <= h_sync ? HS_ON : ~HS_ON;
                vs_q     <= v_sync ? VS_ON : ~VS_ON;
                active_q <= h_active && v_active;
                hval_q   <= h_cnt;
                vval_q   <= v_cnt;
            end
        end
    end

    assign VGA_HS          = hs_q;
    assign VGA_VS          = vs_q;
    assign activeVideo     = active_q;
    assign horizontalValue = hval_q;
    assign verticalValue   = vval_q;
    assign lineStart       = line_start_q;
    assign frameStart      = frame_start_q;

`ifdef VTC_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Counts on the same edge frameStart rises, so frame 1 reads 1.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
        end else if (pix_en && h_zero && v_zero) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frameCount = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vtc_param.sv
module tb_vtc_param;

    logic clk = 1'b0;
    logic rst;
    logic pix_en;

    always #5 clk = ~clk;

    // Active-low instance
    logic        hs, vs, av, ls, fs;
    logic [15:0] hv, vv;
    // Active-high instance
    logic        hs_p, vs_p, av_p, ls_p, fs_p;
    logic [15:0] hv_p, vv_p;
`ifdef VTC_FRAME_CNT_EN
    logic [7:0]  fc, fc_p;
`endif

    vtc_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .CNT_W(16)
    ) dut (
        .clkin(clk), .reset(rst), .pix_en(pix_en),
        .VGA_HS(hs), .VGA_VS(vs), .activeVideo(av),
        .horizontalValue(hv), .verticalValue(vv),
        .lineStart(ls), .frameStart(fs)
`ifdef VTC_FRAME_CNT_EN
        , .frameCount(fc)
`endif
    );

    vtc_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CNT_W(16)
    ) dut_p (
        .clkin(clk), .reset(rst), .pix_en(pix_en),
        .VGA_HS(hs_p), .VGA_VS(vs_p), .activeVideo(av_p),
        .horizontalValue(hv_p), .verticalValue(vv_p),
        .lineStart(ls_p), .frameStart(fs_p)
`ifdef VTC_FRAME_CNT_EN
        , .frameCount(fc_p)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int cyc;
        int h, v, hs, vs, av, ls, fs;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cyc=%0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Holds reset for n clocks, releases just after an edge; cyc restarts at 0
    // so the next tick is the first post-reset edge.
    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_h"},   int'(hv), 0);
        chk({tag, "_v"},   int'(vv), 0);
        chk({tag, "_hs"},  int'(hs), 1);
        chk({tag, "_vs"},  int'(vs), 1);
        chk({tag, "_av"},  int'(av), 0);
        chk({tag, "_ls"},  int'(ls), 0);
        chk({tag, "_fs"},  int'(fs), 0);
        chk({tag, "_hsp"}, int'(hs_p), 0);
        chk({tag, "_vsp"}, int'(vs_p), 0);
    endtask

    int n_hs, n_vs, n_av, n_ls, n_fs, n_hsp, n_vsp, n_bad;
    int prev_h;

    initial begin
        // Cycle index k (k-th edge after release) shows pixel k-1 of a
        // 15 x 8 raster: HS low at cols 10..12, VS low on lines 5..6,
        // active for cols 0..7 on lines 0..3.
        tbl[0]  = '{1,   0,  0, 1, 1, 1, 1, 1};
        tbl[1]  = '{2,   1,  0, 1, 1, 1, 0, 0};
        tbl[2]  = '{8,   7,  0, 1, 1, 1, 0, 0};
        tbl[3]  = '{9,   8,  0, 1, 1, 0, 0, 0};
        tbl[4]  = '{11, 10,  0, 0, 1, 0, 0, 0};
        tbl[5]  = '{13, 12,  0, 0, 1, 0, 0, 0};
        tbl[6]  = '{14, 13,  0, 1, 1, 0, 0, 0};
        tbl[7]  = '{15, 14,  0, 1, 1, 0, 0, 0};
        tbl[8]  = '{16,  0,  1, 1, 1, 1, 1, 0};
        tbl[9]  = '{61,  0,  4, 1, 1, 0, 1, 0};
        tbl[10] = '{76,  0,  5, 1, 0, 0, 1, 0};
        tbl[11] = '{90, 14,  5, 1, 0, 0, 0, 0};
        tbl[12] = '{91,  0,  6, 1, 0, 0, 1, 0};
        tbl[13] = '{106, 0,  7, 1, 1, 0, 1, 0};
        tbl[14] = '{120, 14, 7, 1, 1, 0, 0, 0};
        tbl[15] = '{121, 0,  0, 1, 1, 1, 1, 1};
        tbl[16] = '{131, 10, 0, 0, 1, 0, 0, 0};

        rst    = 1'b0;
        pix_en = 1'b1;
        #1 rst = 1'b1;
        #1;
        // No clock edge has occurred yet: reset acts asynchronously.
        chk_reset_vals("async_reset");
        do_reset(2);

        // ---------------- table-driven full-rate raster ----------------
        for (int i = 0; i < 17; i++) begin
            while (cyc < tbl[i].cyc) tick();
            chk($sformatf("v%0d_h", i),   int'(hv), tbl[i].h);
            chk($sformatf("v%0d_v", i),   int'(vv), tbl[i].v);
            chk($sformatf("v%0d_hs", i),  int'(hs), tbl[i].hs);
            chk($sformatf("v%0d_vs", i),  int'(vs), tbl[i].vs);
            chk($sformatf("v%0d_av", i),  int'(av), tbl[i].av);
            chk($sformatf("v%0d_ls", i),  int'(ls), tbl[i].ls);
            chk($sformatf("v%0d_fs", i),  int'(fs), tbl[i].fs);
            chk($sformatf("v%0d_hsp", i), int'(hs_p), 1 - tbl[i].hs);
            chk($sformatf("v%0d_vsp", i), int'(vs_p), 1 - tbl[i].vs);
            $display("vec %0d cyc=%0d h=%0d v=%0d hs=%0d vs=%0d av=%0d ls=%0d fs=%0d",
                     i, cyc, hv, vv, hs, vs, av, ls, fs);
        end

        // ---------------- one-frame pulse statistics ----------------
        do_reset(2);
`ifdef VTC_FRAME_CNT_EN
        chk("fcnt_reset", int'(fc), 0);
`endif
        n_hs = 0; n_vs = 0; n_av = 0; n_ls = 0; n_fs = 0; n_hsp = 0; n_vsp = 0; n_bad = 0;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (!hs) n_hs++;
            if (!vs) n_vs++;
            if (av) n_av++;
            if (ls) n_ls++;
            if (fs) n_fs++;
            if (hs_p) n_hsp++;
            if (vs_p) n_vsp++;
            if ((hs == 1'b0) != (hv >= 10 && hv <= 12)) n_bad++;
`ifdef VTC_FRAME_CNT_EN
            if (k == 0) chk("fcnt_first", int'(fc), 1);
`endif
        end
        $display("frame stats hs_low=%0d vs_low=%0d av=%0d ls=%0d fs=%0d",
                 n_hs, n_vs, n_av, n_ls, n_fs);
        chk("frame_hs_low", n_hs, 24);
        chk("frame_vs_low", n_vs, 30);
        chk("frame_av", n_av, 32);
        chk("frame_ls", n_ls, 8);
        chk("frame_fs", n_fs, 1);
        chk("frame_hs_high_p", n_hsp, 24);
        chk("frame_vs_high_p", n_vsp, 30);
        chk("hs_col_window_errs", n_bad, 0);
        tick();
        chk("frame2_fs", int'(fs), 1);
`ifdef VTC_FRAME_CNT_EN
        chk("fcnt_second", int'(fc), 2);
`endif

        // ---------------- half-rate pixel enable ----------------
        do_reset(2);
        n_ls = 0; n_fs = 0; n_bad = 0; prev_h = 0;
        for (int k = 1; k <= 240; k++) begin
            pix_en = (k % 2 == 1);
            tick();
            if (ls) n_ls++;
            if (fs) n_fs++;
            if (k % 2 == 0 && int'(hv) != prev_h) n_bad++;
            if (k % 2 == 1 && int'(hv) != ((k - 1) / 2) % 15) n_bad++;
            prev_h = int'(hv);
            if (k == 2) begin
                chk("half_hold_fs", int'(fs), 0);
                chk("half_hold_h", int'(hv), 0);
            end
        end
        $display("half rate ls=%0d fs=%0d coord_errs=%0d", n_ls, n_fs, n_bad);
        chk("half_ls", n_ls, 8);
        chk("half_fs", n_fs, 1);
        chk("half_coord_errs", n_bad, 0);
        pix_en = 1'b1;
        tick();
        chk("half_frame_restart_fs", int'(fs), 1);
        chk("half_frame_restart_v", int'(vv), 0);

        // ---------------- mid-frame asynchronous reset ----------------
        do_reset(2);
        pix_en = 1'b1;
        repeat (37) tick();
        chk("mid_h", int'(hv), 6);
        chk("mid_v", int'(vv), 2);
        chk("mid_av", int'(av), 1);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("mid_async");
        repeat (3) tick();
        chk("mid_held_h", int'(hv), 0);
        chk("mid_held_av", int'(av), 0);
        rst = 1'b0;
        tick();
        $display("restart h=%0d v=%0d av=%0d ls=%0d fs=%0d", hv, vv, av, ls, fs);
        chk("restart_h", int'(hv), 0);
        chk("restart_v", int'(vv), 0);
        chk("restart_av", int'(av), 1);
        chk("restart_ls", int'(ls), 1);
        chk("restart_fs", int'(fs), 1);
        tick();
        chk("restart_h1", int'(hv), 1);
        chk("restart_fs1", int'(fs), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
